operand_sel_pipe: RTL and testbench

OPERAND_SEL_PIPE -- requirements
Module: operand_sel_pipe

---
 rtl/operand_sel_pipe.sv | 127 ++++++++++++
 tb/tb_operand_sel_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sel_pipe.sv
// operand_sel_pipe: selects one operand per request from the register
// candidates or the decoded immediate, then queues the results in a small
// FIFO with a valid/ready handshake on both sides. An illegal select pushes
// zero with a flag and bumps a saturating error counter.
module operand_sel_pipe #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   PB,
    input  logic [DATA_W-1:0]   HI,
    input  logic [DATA_W-1:0]   LO,
    input  logic [DATA_W-1:0]   PC,
    input  logic [15:0]         imm16,
    input  logic [3:0]          Si,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic [DATA_W-1:0]   N,
    output logic                N_illegal,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [3:0] {
        SEL_PB     = 4'd0,
        SEL_HI     = 4'd1,
        SEL_LO     = 4'd2,
        SEL_PC     = 4'd3,
        SEL_IMM_SX = 4'd4,
        SEL_IMM_HI = 4'd5,
        SEL_IMM_ZX = 4'd6,
        SEL_PC8    = 4'd7,
        SEL_SHAMT  = 4'd8
    } sel_e;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic              ill_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [DATA_W-1:0] sel_val;
    logic              sel_ill;
    logic [DATA_W-1:0] imm_hi;
    logic              push;
    logic              pop;

    // Handshake status comes only from registered occupancy.
    always_comb begin
        in_ready  = (count < CNT_W'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        N         = out_valid ? mem[rd_ptr] : '0;
        N_illegal = out_valid ? ill_mem[rd_ptr] : 1'b0;
    end

    // Immediate placed in [31:16]; upper bits (if any) sign-extended from bit 31.
    always_comb begin
        imm_hi       = {DATA_W{imm16[15]}};
        imm_hi[31:0] = {imm16, 16'h0000};
    end

    // Operand select; unlisted codes give zero with the illegal flag.
    always_comb begin
        sel_val = '0;
        sel_ill = 1'b0;
        case (sel_e'(Si))
            SEL_PB:     sel_val = PB;
            SEL_HI:     sel_val = HI;
            SEL_LO:     sel_val = LO;
            SEL_PC:     sel_val = PC;
            SEL_IMM_SX: sel_val = {{(DATA_W-16){imm16[15]}}, imm16};
            SEL_IMM_HI: sel_val = imm_hi;
            SEL_IMM_ZX: sel_val = {{(DATA_W-16){1'b0}}, imm16};
            SEL_PC8:    sel_val = PC + DATA_W'(8);
            SEL_SHAMT:  sel_val = {{(DATA_W-5){1'b0}}, imm16[10:6]};
            default:    sel_ill = 1'b1;
        endcase
    end

    // Entry storage; contents are don't-care until covered by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]     <= sel_val;
            ill_mem[wr_ptr] <= sel_ill;
        end
    end

    // Pointers and occupancy; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Saturating count of accepted illegal selects; flush does not clear it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_count <= '0;
        end else if (push && sel_ill && (err_count != '1)) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_sel_pipe.sv
// Directed bench for operand_sel_pipe with DATA_W=32, DEPTH=2, ERRCNT_W=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_operand_sel_pipe;

    logic        clk;
    logic        reset_n;
    logic [31:0] PB, HI, LO, PC;
    logic [15:0] imm16;
    logic [3:0]  Si;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [31:0] N;
    logic        N_illegal;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  err_count;

    int n_checks = 0;
    int n_fail   = 0;

    operand_sel_pipe #(
        .DATA_W(32),
        .DEPTH(2),
        .ERRCNT_W(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .PB(PB),
        .HI(HI),
        .LO(LO),
        .PC(PC),
        .imm16(imm16),
        .Si(Si),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .N(N),
        .N_illegal(N_illegal),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
        n_checks++; if (N !== 32'h0) begin n_fail++; $display("FAIL rst_N got %h exp 0", N); end
        n_checks++; if (N_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_N_illegal got %b exp 0", N_illegal); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        n_checks++; if (err_count !== 8'h00) begin n_fail++; $display("FAIL rst_err_count got %h exp 00", err_count); end
        reset_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_release got rdy=%b vld=%b exp 1/0", in_ready, out_valid); end
    endtask

    task automatic test_sign_ext();
        Si = 4'd4; imm16 = 16'h8001; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || N !== 32'hFFFF8001 || N_illegal !== 1'b0) begin n_fail++; $display("FAIL sext_N got vld=%b N=%h ill=%b exp 1/ffff8001/0", out_valid, N, N_illegal); end
        tick();
        n_checks++; if (out_valid !== 1'b0 || N !== 32'h0) begin n_fail++; $display("FAIL sext_empty got vld=%b N=%h exp 0/0", out_valid, N); end
    endtask

    task automatic test_order();
        out_ready = 1'b0;
        Si = 4'd5; imm16 = 16'h1234; in_valid = 1'b1;
        tick();
        Si = 4'd7; PC = 32'hFFFFFFFC;
        tick();
        in_valid = 1'b0;
        n_checks++; if (N !== 32'h12340000 || out_valid !== 1'b1) begin n_fail++; $display("FAIL order_first got vld=%b N=%h exp 1/12340000", out_valid, N); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL order_full got in_ready=%b exp 0", in_ready); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (N !== 32'h00000004 || out_valid !== 1'b1) begin n_fail++; $display("FAIL order_second got vld=%b N=%h exp 1/00000004", out_valid, N); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty got vld=%b exp 0", out_valid); end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        PB = 32'hA; HI = 32'hB; LO = 32'hC;
        Si = 4'd0; in_valid = 1'b1;
        tick();
        Si = 4'd1;
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b exp 0", in_ready); end
        Si = 4'd2;
        tick();
        n_checks++; if (N !== 32'hA || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold got N=%h rdy=%b exp a/0", N, in_ready); end
        // Pop while full with a request pending: the push must be refused.
        out_ready = 1'b1;
        tick();
        n_checks++; if (N !== 32'hB || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop_no_push got N=%h rdy=%b exp b/1", N, in_ready); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained got vld=%b N=%h exp 0", out_valid, N); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        logic [31:0] exps [4];
        vals[0] = 16'h0001; exps[0] = 32'h00000001;
        vals[1] = 16'hFFFF; exps[1] = 32'h0000FFFF;
        vals[2] = 16'h8000; exps[2] = 32'h00008000;
        vals[3] = 16'h1234; exps[3] = 32'h00001234;
        Si = 4'd6; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            imm16 = vals[i];
            tick();
            n_checks++; if (N !== exps[i] || out_valid !== 1'b1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_%0d got N=%h vld=%b rdy=%b exp %h/1/1", i, N, out_valid, in_ready, exps[i]); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got vld=%b exp 0", out_valid); end
    endtask

    task automatic test_selects();
        logic [3:0]  si_t  [5];
        logic [15:0] imm_t [5];
        logic [31:0] exp_t [5];
        si_t[0] = 4'd8; imm_t[0] = 16'h07C0; exp_t[0] = 32'h0000001F;
        si_t[1] = 4'd8; imm_t[1] = 16'hF83F; exp_t[1] = 32'h00000000;
        si_t[2] = 4'd3; imm_t[2] = 16'h0000; exp_t[2] = 32'hDEADBEEF;
        si_t[3] = 4'd5; imm_t[3] = 16'h8000; exp_t[3] = 32'h80000000;
        si_t[4] = 4'd4; imm_t[4] = 16'h7FFF; exp_t[4] = 32'h00007FFF;
        PC = 32'hDEADBEEF; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Si = si_t[i]; imm16 = imm_t[i];
            tick();
            n_checks++; if (N !== exp_t[i] || N_illegal !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL sel_%0d got N=%h ill=%b vld=%b exp %h/0/1", i, N, N_illegal, out_valid, exp_t[i]); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        // Full buffer, flush with push and pop in the same cycle.
        out_ready = 1'b0; Si = 4'd0; in_valid = 1'b1;
        PB = 32'h1;
        tick();
        PB = 32'h2;
        tick();
        flush = 1'b1; out_ready = 1'b1; Si = 4'd1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || N !== 32'h0) begin n_fail++; $display("FAIL flush_full got vld=%b rdy=%b N=%h exp 0/1/0", out_valid, in_ready, N); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_nothing got vld=%b exp 0", out_valid); end
        // One entry, flush with an accepted illegal push: counter still bumps.
        out_ready = 1'b0; Si = 4'd0; in_valid = 1'b1;
        tick();
        flush = 1'b1; Si = 4'd12;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || err_count !== 8'd1) begin n_fail++; $display("FAIL flush_err got vld=%b err=%0d exp 0/1", out_valid, err_count); end
    endtask

    task automatic test_illegal();
        int exp_err;
        PB = 32'h5555AAAA; Si = 4'd12; out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            exp_err = (i + 2 > 255) ? 255 : i + 2;
            n_checks++; if (N !== 32'h0 || N_illegal !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_%0d got N=%h ill=%b vld=%b exp 0/1/1", i, N, N_illegal, out_valid); end
            n_checks++; if (err_count !== exp_err[7:0]) begin n_fail++; $display("FAIL errcnt_%0d got %0d exp %0d", i, err_count, exp_err); end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || err_count !== 8'hFF) begin n_fail++; $display("FAIL illegal_end got vld=%b err=%h exp 0/ff", out_valid, err_count); end
    endtask

    task automatic test_reset_mid();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        Si = 4'd13; out_ready = 1'b1; in_valid = 1'b1;
        repeat (5) tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0; Si = 4'd0; in_valid = 1'b1;
        repeat (2) tick();
        n_checks++; if (err_count !== 8'd5 || in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset got err=%0d rdy=%b vld=%b exp 5/0/1", err_count, in_ready, out_valid); end
        reset_n = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1 || N !== 32'h0) begin n_fail++; $display("FAIL mid_reset got vld=%b err=%0d rdy=%b N=%h exp 0/0/1/0", out_valid, err_count, in_ready, N); end
        reset_n = 1'b1; in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset got vld=%b exp 0", out_valid); end
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        PB = 32'h11111111; HI = 32'h22222222; LO = 32'h33333333; PC = 32'h44444444;
        imm16 = 16'h0; Si = 4'd0;
        test_reset();
        test_sign_ext();
        test_order();
        test_full();
        test_back_to_back();
        test_selects();
        test_flush();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
